// File: rtl/memshare_config_pkg.sv
// ---------------------------------------------------------------------------
// memshare_config_pkg
//   Shared configuration for the memory-share scheduling controller:
//   widths, the FSM state and request-class enums, the L1PA entry layout,
//   the base-page constants and the lane classifier.
// ---------------------------------------------------------------------------
package memshare_config_pkg;

    localparam int SHARE_GROUP_SIZE        = 5;
    localparam int RQST_ADDR_BITWIDTH      = 2;
    localparam int RQST_MODE_BITWIDTH      = 2;
    localparam int MEMSHARE_DRC_NUM        = 1;
    localparam int L1PA_REGFILE_PAGE_NUM   = 8;
    localparam int L1PA_REGFILE_ADDR_WIDTH = $clog2(L1PA_REGFILE_PAGE_NUM);
    localparam int L1PA_SHIFT_WIDTH        = $clog2(SHARE_GROUP_SIZE);
    localparam int L1PA_REGFILE_PAGE_WIDTH = 1 + L1PA_SHIFT_WIDTH;
    localparam int RQST_BUS_WIDTH          = RQST_ADDR_BITWIDTH * SHARE_GROUP_SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } state_t;

    typedef enum logic {
        SEQ1 = 1'b0,
        SEQ2 = 1'b1
    } seq_class_t;

    // One register-file page: gtr marks the last step of a sequence.
    typedef struct packed {
        logic                        gtr;
        logic [L1PA_SHIFT_WIDTH-1:0] shift;
    } l1pa_entry_t;

    localparam logic [L1PA_REGFILE_ADDR_WIDTH-1:0] BASE_PAGE_SEQ1 = '0;
    localparam logic [L1PA_REGFILE_ADDR_WIDTH-1:0] BASE_PAGE_SEQ2 = L1PA_REGFILE_ADDR_WIDTH'(1);

    // Counts distinct lane addresses, saturating at two: a lane is new when
    // no lower-numbered lane carries the same address.
    function automatic seq_class_t classifyLanes(input logic [RQST_BUS_WIDTH-1:0] addrs);
        logic [1:0] distinct;
        logic       isNew;
        distinct = 2'd0;
        for (int i = 0; i < SHARE_GROUP_SIZE; i++) begin
            isNew = 1'b1;
            for (int j = 0; j < i; j++) begin
                if (addrs[i*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH] ==
                    addrs[j*RQST_ADDR_BITWIDTH +: RQST_ADDR_BITWIDTH]) begin
                    isNew = 1'b0;
                end
            end
            if (isNew && (distinct != 2'd2)) begin
                distinct = distinct + 2'd1;
            end
        end
        return (distinct == 2'd1) ? SEQ1 : SEQ2;
    endfunction

    function automatic logic [L1PA_REGFILE_ADDR_WIDTH-1:0] basePage(input seq_class_t cls);
        return (cls == SEQ1) ? BASE_PAGE_SEQ1 : BASE_PAGE_SEQ2;
    endfunction

endpackage

// File: rtl/memshare_control_wrapper_if.sv
// ---------------------------------------------------------------------------
// memshare_control_wrapper_if
//   Bundles the request, schedule-output, register-file write and debug
//   signals of the memory-share controller.
//   master : drives requests, mode and register-file writes; observes outputs
//   slave  : the controller
//   Signals:
//     rqst_addr_i      lane request addresses, lane i at [(i+1)*W-1:i*W]
//     modeSet_i        0 = idle, nonzero = schedule
//     is_drc_o         1 = more sequence steps pending, upstream must hold
//     l1pa_shift_o     shift field of the current L1PA entry
//     isGtr_o          gtr bit of the current entry (last step)
//     regType0_*       register-file write port
//     dbgState/dbgPtr  FSM state and read pointer
//     dbgRqstAddr      latched request addresses
//   Handshake: there is no ready; a request is taken on any rising edge where
//   modeSet_i != 0 and the controller is idle or showing a gtr step. While
//   is_drc_o = 1 the requester must hold its address; changes are ignored.
// ---------------------------------------------------------------------------
interface memshare_control_wrapper_if;
    import memshare_config_pkg::*;

    logic [RQST_BUS_WIDTH-1:0]          rqst_addr_i;
    logic [RQST_MODE_BITWIDTH-1:0]      modeSet_i;
    logic [MEMSHARE_DRC_NUM-1:0]        is_drc_o;
    logic [L1PA_SHIFT_WIDTH-1:0]        l1pa_shift_o;
    logic                               isGtr_o;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0] regType0_waddr_i;
    logic [L1PA_REGFILE_PAGE_WIDTH-1:0] regType0_wdata_i;
    logic                               regType0_we_i;
    state_t                             dbgState;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0] dbgPtr;
    logic [RQST_BUS_WIDTH-1:0]          dbgRqstAddr;

    modport master (
        output rqst_addr_i, modeSet_i,
        output regType0_waddr_i, regType0_wdata_i, regType0_we_i,
        input  is_drc_o, l1pa_shift_o, isGtr_o,
        input  dbgState, dbgPtr, dbgRqstAddr
    );

    modport slave (
        input  rqst_addr_i, modeSet_i,
        input  regType0_waddr_i, regType0_wdata_i, regType0_we_i,
        output is_drc_o, l1pa_shift_o, isGtr_o,
        output dbgState, dbgPtr, dbgRqstAddr
    );

endinterface

// File: rtl/l1pa_regfile.sv
// ---------------------------------------------------------------------------
// l1pa_regfile
//   Software-loadable L1PA shift-sequence storage.
//   Ports:
//     sys_clk  clock
//     we       write enable (not gated by reset, contents never cleared)
//     waddr    write page
//     wdata    write data {gtr, shift}
//     raddr    read page
//     rdata    asynchronous read of page raddr
// ---------------------------------------------------------------------------
module l1pa_regfile
    import memshare_config_pkg::*;
(
    input  logic                               sys_clk,
    input  logic                               we,
    input  logic [L1PA_REGFILE_ADDR_WIDTH-1:0] waddr,
    input  logic [L1PA_REGFILE_PAGE_WIDTH-1:0] wdata,
    input  logic [L1PA_REGFILE_ADDR_WIDTH-1:0] raddr,
    output l1pa_entry_t                        rdata
);

    logic [L1PA_REGFILE_PAGE_WIDTH-1:0] pages [L1PA_REGFILE_PAGE_NUM];

    // No reset: software programs the sequences, possibly while the
    // controller is still held in reset.
    always_ff @(posedge sys_clk) begin
        if (we) begin
            pages[waddr] <= wdata;
        end
    end

    assign rdata = pages[raddr];

endmodule

// File: rtl/memshare_control_wrapper.sv
// ---------------------------------------------------------------------------
// memshare_control_wrapper
//   Memory-share scheduling controller for one share group. Classifies the
//   lane addresses into a 1-sequence or 2-sequence pattern, then walks the
//   matching L1PA shift sequence, holding is_drc_o high until the gtr step.
//   Ports:
//     sys_clk  clock, rising edge
//     rstn     asynchronous reset, active high (name kept for integration)
//     bus      memshare_control_wrapper_if.slave
// ---------------------------------------------------------------------------
module memshare_control_wrapper
    import memshare_config_pkg::*;
(
    input  logic                        sys_clk,
    input  logic                        rstn,
    memshare_control_wrapper_if.slave   bus
);

    state_t                             state;
    state_t                             stateNext;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0] ptr;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0] ptrNext;
    logic [RQST_BUS_WIDTH-1:0]          rqstAddrQ;
    logic [RQST_BUS_WIDTH-1:0]          rqstAddrNext;
    l1pa_entry_t                        curEntry;
    seq_class_t                         rqstClass;
    logic [L1PA_REGFILE_ADDR_WIDTH-1:0] rqstBase;
    logic                               modeActive;

    l1pa_regfile uRegfile (
        .sys_clk (sys_clk),
        .we      (bus.regType0_we_i),
        .waddr   (bus.regType0_waddr_i),
        .wdata   (bus.regType0_wdata_i),
        .raddr   (ptr),
        .rdata   (curEntry)
    );

    assign modeActive = |bus.modeSet_i;
    assign rqstClass  = classifyLanes(bus.rqst_addr_i);
    assign rqstBase   = basePage(rqstClass);

    // State register
    always_ff @(posedge sys_clk or posedge rstn) begin
        if (rstn) begin
            state     <= IDLE;
            ptr       <= '0;
            rqstAddrQ <= '0;
        end else begin
            state     <= stateNext;
            ptr       <= ptrNext;
            rqstAddrQ <= rqstAddrNext;
        end
    end

    // Next-state logic. A gtr step doubles as the accept slot for the next
    // request, so back-to-back requests run without an idle bubble.
    always_comb begin
        stateNext    = state;
        ptrNext      = ptr;
        rqstAddrNext = rqstAddrQ;
        unique case (state)
            IDLE: begin
                if (modeActive) begin
                    stateNext    = WALK;
                    ptrNext      = rqstBase;
                    rqstAddrNext = bus.rqst_addr_i;
                end
            end
            WALK: begin
                if (curEntry.gtr) begin
                    if (modeActive) begin
                        ptrNext      = rqstBase;
                        rqstAddrNext = bus.rqst_addr_i;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    // Natural wrap of the page pointer past the last page.
                    ptrNext = ptr + L1PA_REGFILE_ADDR_WIDTH'(1);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs depend only on flops (state, ptr, register file), so they
    // appear one cycle after the edge that sampled the request and drop to
    // zero as soon as reset is asserted.
    always_comb begin
        bus.l1pa_shift_o = '0;
        bus.isGtr_o      = 1'b0;
        bus.is_drc_o     = '0;
        if (state == WALK) begin
            bus.l1pa_shift_o = curEntry.shift;
            bus.isGtr_o      = curEntry.gtr;
            bus.is_drc_o     = {MEMSHARE_DRC_NUM{~curEntry.gtr}};
        end
    end

    assign bus.dbgState    = state;
    assign bus.dbgPtr      = ptr;
    assign bus.dbgRqstAddr = rqstAddrQ;

endmodule

// File: tb/tb_memshare_control_wrapper.sv
module tb_memshare_control_wrapper;
    import memshare_config_pkg::*;

    logic sys_clk;
    logic rstn;

    memshare_control_wrapper_if bus ();

    memshare_control_wrapper dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .bus     (bus)
    );

    // Clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: a shadow of the page table and the queue of sequence
    // steps still to be shown for the request being served.
    logic [3:0] modelPages [8];
    logic [3:0] expQ [$];
    logic [3:0] curEntry   = 4'd0;
    logic       curWalking = 1'b0;

    // Expected {is_drc, isGtr, shift}
    function automatic logic [4:0] expOut();
        if (!curWalking) return 5'd0;
        return {~curEntry[3], curEntry[3], curEntry[2:0]};
    endfunction

    // One clock edge of the model: continue the pending sequence, or when
    // the previous one has finished, take a new request and lay out all its
    // steps up to the first gtr page.
    task automatic modelEdge(input logic [9:0] addrs, input logic [1:0] mode);
        logic [3:0] seen;
        int         p;
        logic [3:0] e;
        if (expQ.size() != 0) begin
            curEntry   = expQ.pop_front();
            curWalking = 1'b1;
        end else if (mode != 2'd0) begin
            seen = 4'd0;
            for (int i = 0; i < 5; i++) seen[addrs[2*i +: 2]] = 1'b1;
            p = ($countones(seen) == 1) ? 0 : 1;
            for (int k = 0; k < 16; k++) begin
                e = modelPages[p];
                if (k == 0) curEntry = e;
                else expQ.push_back(e);
                if (e[3]) break;
                p = (p + 1) % 8;
            end
            curWalking = 1'b1;
        end else begin
            curWalking = 1'b0;
            curEntry   = 4'd0;
        end
    endtask

    // Driver: apply inputs at the falling edge, advance model, wait a cycle.
    task automatic tick(input logic [9:0] addrs, input logic [1:0] mode,
                        input logic we, input logic [2:0] wa, input logic [3:0] wd);
        bus.rqst_addr_i      = addrs;
        bus.modeSet_i        = mode;
        bus.regType0_we_i    = we;
        bus.regType0_waddr_i = wa;
        bus.regType0_wdata_i = wd;
        if (we) modelPages[wa] = wd;
        if (rstn) begin
            expQ.delete();
            curWalking = 1'b0;
            curEntry   = 4'd0;
        end else begin
            modelEdge(addrs, mode);
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        bus.regType0_we_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] act;
        rstn = 1'b1;
        tick(10'h155, 2'd1, 1'b1, 3'd0, 4'b1000);
        tick(10'h1A5, 2'd1, 1'b1, 3'd1, 4'b0001);
        tick(10'h155, 2'd1, 1'b1, 3'd2, 4'b1011);
        for (int i = 3; i < 8; i++) tick(10'h155, 2'd1, 1'b1, 3'(i), {1'b1, 3'(i)});
        act = {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o};
        nChecks++;
        if (act !== 5'd0) begin
            nFails++; $display("FAIL reset_outputs: got %b expected 00000", act);
        end
        nChecks++;
        if (bus.dbgState !== IDLE) begin
            nFails++; $display("FAIL reset_state: got %0d expected IDLE", bus.dbgState);
        end
        nChecks++;
        if (bus.dbgPtr !== 3'd0) begin
            nFails++; $display("FAIL reset_ptr: got %0d expected 0", bus.dbgPtr);
        end
        for (int i = 0; i < 8; i++) begin
            nChecks++;
            if (dut.uRegfile.pages[i] !== modelPages[i]) begin
                nFails++;
                $display("FAIL preload_page%0d: got %b expected %b", i, dut.uRegfile.pages[i], modelPages[i]);
            end
        end
        rstn = 1'b0;
    endtask

    task automatic test_one_seq();
        tick(10'h155, 2'd1, 1'b0, 3'd0, 4'd0);
        nChecks++;
        if ({bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o} !== 5'b0_1_000) begin
            nFails++; $display("FAIL one_seq_step: got %b expected 01000", {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o});
        end
        tick(10'h2AA, 2'd1, 1'b0, 3'd0, 4'd0);
        nChecks++;
        if ({bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o} !== 5'b0_1_000) begin
            nFails++; $display("FAIL one_seq_next: got %b expected 01000", {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o});
        end
        nChecks++;
        if (bus.dbgRqstAddr !== 10'h2AA) begin
            nFails++; $display("FAIL one_seq_latch: got %h expected 2aa", bus.dbgRqstAddr);
        end
        tick(10'h000, 2'd0, 1'b0, 3'd0, 4'd0);
        nChecks++;
        if ({bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o} !== 5'd0 || bus.dbgState !== IDLE) begin
            nFails++; $display("FAIL one_seq_idle: got %b state %0d expected 00000 IDLE", {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o}, bus.dbgState);
        end
    endtask

    task automatic test_two_seq();
        tick(10'h1A5, 2'd1, 1'b0, 3'd0, 4'd0);
        nChecks++;
        if ({bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o} !== 5'b1_0_001) begin
            nFails++; $display("FAIL two_seq_step1: got %b expected 10001", {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o});
        end
        tick(10'h155, 2'd1, 1'b0, 3'd0, 4'd0);
        nChecks++;
        if ({bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o} !== 5'b0_1_011) begin
            nFails++; $display("FAIL two_seq_step2: got %b expected 01011", {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o});
        end
        nChecks++;
        if (bus.dbgRqstAddr !== 10'h1A5) begin
            nFails++; $display("FAIL two_seq_hold: got %h expected 1a5", bus.dbgRqstAddr);
        end
        tick(10'h000, 2'd0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic test_back_to_back();
        logic [9:0] addrs [5];
        logic [4:0] drcExp;
        logic [4:0] gtrExp;
        addrs[0] = 10'h155;  // one distinct address
        addrs[1] = 10'h1A5;  // two distinct
        addrs[2] = 10'h3FF;  // ignored, walk in progress
        addrs[3] = 10'h0E4;  // four distinct, saturates to two
        addrs[4] = 10'h2AA;  // ignored
        drcExp = 5'b01010;   // index = cycle
        gtrExp = 5'b10101;
        for (int c = 0; c < 5; c++) begin
            tick(addrs[c], 2'd1, 1'b0, 3'd0, 4'd0);
            nChecks++;
            if (bus.is_drc_o !== drcExp[4-c] || bus.isGtr_o !== gtrExp[4-c]) begin
                nFails++;
                $display("FAIL b2b_cycle%0d: got drc %b gtr %b expected drc %b gtr %b", c, bus.is_drc_o, bus.isGtr_o, drcExp[4-c], gtrExp[4-c]);
            end
        end
        tick(10'h000, 2'd0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic test_live_write();
        tick(10'h155, 2'd1, 1'b0, 3'd0, 4'd0);
        tick(10'h155, 2'd1, 1'b1, 3'd0, 4'b1101);
        nChecks++;
        if ({bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o} !== 5'b0_1_101) begin
            nFails++; $display("FAIL live_write: got %b expected 01101", {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o});
        end
        tick(10'h155, 2'd1, 1'b1, 3'd0, 4'b1000);
        tick(10'h000, 2'd0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic test_reset_mid_walk();
        tick(10'h1A5, 2'd1, 1'b0, 3'd0, 4'd0);
        #2 rstn = 1'b1;
        #1;
        nChecks++;
        if ({bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o} !== 5'd0 || bus.dbgState !== IDLE) begin
            nFails++; $display("FAIL async_reset: got %b state %0d expected 00000 IDLE", {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o}, bus.dbgState);
        end
        @(negedge sys_clk);
        tick(10'h1A5, 2'd1, 1'b0, 3'd0, 4'd0);
        rstn = 1'b0;
        tick(10'h2AA, 2'd1, 1'b0, 3'd0, 4'd0);
        nChecks++;
        if ({bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o} !== 5'b0_1_000) begin
            nFails++; $display("FAIL post_reset_restart: got %b expected 01000", {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o});
        end
        tick(10'h000, 2'd0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            tick(10'($urandom), 2'd0, 1'b0, 3'd0, 4'd0);
            nChecks++;
            if ({bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o} !== 5'd0) begin
                nFails++; $display("FAIL idle_cycle%0d: got %b expected 00000", c, {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o});
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] addrs;
        logic [1:0] mode;
        logic [3:0] wd;
        logic [4:0] act;
        // Random page table; page 7 always ends a sequence so every walk stops.
        for (int i = 0; i < 8; i++) begin
            wd = 4'($urandom);
            if (i == 7) wd[3] = 1'b1;
            tick(10'($urandom), 2'd0, 1'b1, 3'(i), wd);
        end
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 1) == 1) addrs = {5{2'($urandom_range(0, 3))}};
            else addrs = 10'($urandom);
            mode = ($urandom_range(0, 9) < 7) ? 2'($urandom_range(1, 3)) : 2'd0;
            tick(addrs, mode, 1'b0, 3'd0, 4'd0);
            act = {bus.is_drc_o, bus.isGtr_o, bus.l1pa_shift_o};
            nChecks++;
            if (act !== expOut()) begin
                nFails++; $display("FAIL random_cycle%0d: got %b expected %b", c, act, expOut());
            end
        end
        for (int c = 0; c < 10; c++) tick(10'h000, 2'd0, 1'b0, 3'd0, 4'd0);
    endtask

    initial begin
        rstn                 = 1'b1;
        bus.rqst_addr_i      = '0;
        bus.modeSet_i        = '0;
        bus.regType0_we_i    = 1'b0;
        bus.regType0_waddr_i = '0;
        bus.regType0_wdata_i = '0;
        for (int i = 0; i < 8; i++) modelPages[i] = 4'd0;
        test_reset();
        test_one_seq();
        test_two_seq();
        test_back_to_back();
        test_live_write();
        test_reset_mid_walk();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/memshare_control_wrapper.md
Name: memshare_control_wrapper

Overview:
Memory-share scheduling controller for one share group of SHARE_GROUP_SIZE lanes. Each cycle it classifies the lanes' request addresses into a 1-sequence (all lanes same address) or 2-sequence (exactly two distinct addresses) pattern. It then walks the matching L1PA shift sequence from an internal, software-loadable L1PA register file. It raises is_drc_o while more sequence steps remain, which stalls the upstream message-pass buffer address generator.

Parameters:
SHARE_GROUP_SIZE, 5, lanes per share group
RQST_ADDR_BITWIDTH, 2, address bits per lane request
RQST_MODE_BITWIDTH, 2, mode field width
MEMSHARE_DRC_NUM, 1, number of DRC (stall) flags
L1PA_REGFILE_PAGE_NUM, 8, register-file entries
L1PA_REGFILE_ADDR_WIDTH, 3, clog2(PAGE_NUM)
L1PA_REGFILE_PAGE_WIDTH, 4, entry = {gtr(1), shift(clog2(SHARE_GROUP_SIZE))}

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rstn  in  1  reset; asynchronous, active-high (asserted = 1); port name kept for integration
rqst_addr_i  in  RQST_ADDR_BITWIDTH*SHARE_GROUP_SIZE  lane i address at bits [(i+1)*W-1 : i*W]
modeSet_i  in  RQST_MODE_BITWIDTH  0 = idle, any nonzero = schedule
is_drc_o  out  MEMSHARE_DRC_NUM  1 = further sequence steps pending, upstream must hold its address
l1pa_shift_o  out  clog2(SHARE_GROUP_SIZE)  shift field of the current L1PA entry
isGtr_o  out  1  gtr bit of the current entry (last step of the sequence)
regType0_waddr_i  in  L1PA_REGFILE_ADDR_WIDTH  register-file write address
regType0_wdata_i  in  L1PA_REGFILE_PAGE_WIDTH  register-file write data
regType0_we_i  in  1  register-file write enable, active high

Behaviour:
- Register file: PAGE_NUM x PAGE_WIDTH flops.
  - Synchronous write when regType0_we_i = 1; the write is honoured even while reset is asserted.
  - Contents are NOT cleared by reset.
  - Read is asynchronous from the read pointer.
  - A write to the entry currently being read takes effect the next cycle.
- Classifier (combinational): count distinct lane addresses.
  - 1 distinct -> class 1SEQ, base page 0.
  - 2 distinct -> class 2SEQ, base page 1.
  - More than 2 distinct -> class 2SEQ, base page 1 (saturates).
- FSM states IDLE and WALK; the read pointer ptr is a register.
  - IDLE: if modeSet_i != 0, latch rqst_addr_i, set ptr = base, go to WALK. Otherwise stay in IDLE.
  - WALK: the entry at ptr drives the outputs.
    - If the entry's gtr = 1 and modeSet_i != 0: immediately accept the next request (ptr = new base), stay in WALK.
    - If gtr = 1 and modeSet_i == 0: go to IDLE.
    - If gtr = 0: ptr = ptr+1, stay in WALK. The pointer wraps 7 -> 0.
  - New rqst_addr_i values are ignored while gtr = 0 (the request is latched).
- Outputs are registered with 1-cycle latency from the request sample edge:
  - l1pa_shift_o = entry[shift]
  - isGtr_o = entry[gtr]
  - is_drc_o = WALK && !entry[gtr], replicated to all MEMSHARE_DRC_NUM bits
- In IDLE: is_drc_o = 0, isGtr_o = 0, l1pa_shift_o = 0.
- Reset values: all outputs 0, state IDLE, ptr 0. Reset mid-walk aborts immediately, and the first post-reset request restarts from base.
- modeSet_i dropping to 0 mid-walk does not abort; the walk completes to gtr, then returns to IDLE.

Decomposition:
- Package memshare_config_pkg: all parameters above, the state enum {IDLE, WALK}, the class enum {SEQ1, SEQ2}, and base-page constants 0 and 1.
- One natural sub-module: l1pa_regfile, holding the storage plus the write port and async read.
- The classifier and FSM live in the top module.

Test Plan:
- Preload page0 = 4'b1_000 and page1 = 4'b0_001, page2 = 4'b1_011 via regType0_*; read back through hierarchy -> values match, including writes issued during reset.
- Mode 1, all lanes addr 2'b01 -> one cycle later shift = 0, isGtr = 1, is_drc = 0; the next request is accepted the following cycle.
- Mode 1, lanes {01,01,10,10,01} -> cycle 1: shift = 1, isGtr = 0, is_drc = 1. Cycle 2: shift = 3, isGtr = 1, is_drc = 0. The request change applied during cycle 1 is ignored.
- Sequence 1seq, 2seq, 2seq back-to-back -> is_drc pattern 0,1,0,1,0 with isGtr 1,0,1,0,1.
- Assert rstn during the 2SEQ cycle-1 step -> outputs 0 immediately (asynchronous), state IDLE; after deassert, an all-equal request gives shift 0, isGtr 1.
- modeSet_i = 0 with arbitrary addresses -> outputs stay 0 indefinitely.
